// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: execute->MEM and MEM->writeback payloads,
// load/store funct3 codes, FSM state encoding and an access-size decoder.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic [2:0]  mem_funct3;
  } ex_to_mem_s;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
  } mem_to_wb_s;

  // Unlisted funct3 codes fall back to a full word access.
  function automatic mem_size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and memory (slave).
//   req/we/addr/wdata/be : request side, driven by the master
//   gnt                  : request accepted this cycle
//   rvalid/rdata         : load response
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it according to funct3.
//   rdata_i  : raw word from memory
//   addr_i   : low address bits of the access
//   funct3_i : load type
//   result_o : 32-bit writeback value
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Half accesses only look at addr[1]; addr[0] is ignored here.
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sign_ext = ~funct3_i[2];
    case (access_size(funct3_i))
      SZ_BYTE: result_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through, runs byte/half/word loads
// and stores on the data-memory bus, and stalls execute while busy.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   ex_to_mem_i   : instruction from execute (sampled only in IDLE)
//   ex_valid_i    : ex_to_mem_i is valid
//   mem_stall_o   : upstream must hold and not advance
//   mem_to_wb_o   : registered writeback payload, valid is a 1-cycle pulse
//   mem_err_o     : 1-cycle error pulse, coincident with the aborted result
//   dmem          : data-memory bus (master side)
// Optional build macro MEM_MISALIGN_CHECK_EN: reject misaligned half/word
// accesses without touching the bus.
//
// state | meaning
// IDLE  | accept new instruction; ALU ops complete here
// REQ   | dmem_req held until gnt (a load may also see rvalid here)
// WAIT  | load granted, waiting for rvalid
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_to_mem_s  ex_to_mem_i,
  input  logic        ex_valid_i,
  output logic        mem_stall_o,
  output mem_to_wb_s  mem_to_wb_o,
  output logic        mem_err_o,
  mem_stage_if.master dmem
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  mem_state_e  state_q, state_d;
  ex_to_mem_s  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_to_wb_s  wb_q, wb_d;
  logic        err_q, err_d;

  logic        mem_op;
  logic        misalign;
  logic        timeout;
  logic        in_req;
  logic [31:0] load_data;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  assign mem_op  = ex_to_mem_i.mem_read | ex_to_mem_i.mem_write;
  assign timeout = (cnt_q == TIMEOUT_CNT);
  assign in_req  = (state_q == ST_REQ);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (access_size(ex_to_mem_i.mem_funct3))
      SZ_HALF: misalign = ex_to_mem_i.alu_result[0];
      SZ_WORD: misalign = |ex_to_mem_i.alu_result[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata_i  (dmem.rdata),
    .addr_i   (op_q.alu_result[1:0]),
    .funct3_i (op_q.mem_funct3),
    .result_o (load_data)
  );

  always_comb begin
    case (access_size(op_q.mem_funct3))
      SZ_BYTE: begin
        store_be    = 4'b0001 << op_q.alu_result[1:0];
        store_wdata = {4{op_q.write_data[7:0]}};
      end
      SZ_HALF: begin
        store_be    = 4'b0011 << {op_q.alu_result[1], 1'b0};
        store_wdata = {2{op_q.write_data[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = op_q.write_data;
      end
    endcase
  end

  // Bus outputs are forced low outside REQ so a reset drops them at once.
  assign dmem.req   = in_req;
  assign dmem.we    = in_req & op_q.mem_write;
  assign dmem.addr  = in_req ? {op_q.alu_result[31:2], 2'b00} : 32'd0;
  assign dmem.be    = in_req ? (op_q.mem_write ? store_be : 4'b1111) : 4'b0000;
  assign dmem.wdata = (in_req & op_q.mem_write) ? store_wdata : 32'd0;

  assign mem_stall_o = (state_q != ST_IDLE) | (ex_valid_i & mem_op);
  assign mem_to_wb_o = wb_q;
  assign mem_err_o   = err_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = 8'd0;
    wb_d           = wb_q;
    wb_d.valid     = 1'b0;
    err_d          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid_i && mem_op) begin
          op_d          = ex_to_mem_i;
          op_d.mem_read = ex_to_mem_i.mem_read & ~ex_to_mem_i.mem_write;
          if (misalign) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = 1'b0;
            wb_d.rd        = ex_to_mem_i.rd;
            wb_d.wb_data   = 32'd0;
            err_d          = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end else if (ex_valid_i) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = ex_to_mem_i.reg_write;
          wb_d.rd        = ex_to_mem_i.rd;
          wb_d.wb_data   = ex_to_mem_i.alu_result;
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Completion wins over a timeout landing in the same cycle.
        if (in_req && dmem.gnt && op_q.mem_write) begin
          state_d        = ST_IDLE;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          wb_d.rd        = op_q.rd;
        end else if ((in_req ? dmem.gnt : 1'b1) && dmem.rvalid && op_q.mem_read) begin
          state_d        = ST_IDLE;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = op_q.reg_write;
          wb_d.rd        = op_q.rd;
          wb_d.wb_data   = load_data;
        end else if (timeout) begin
          state_d        = ST_IDLE;
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          wb_d.rd        = op_q.rd;
          wb_d.wb_data   = 32'd0;
          err_d          = 1'b1;
        end else if (in_req && dmem.gnt) begin
          state_d = ST_WAIT;
        end
        if (state_d == ST_IDLE) cnt_d = 8'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= 8'd0;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 4;

  logic       clk;
  logic       rst_n;
  ex_to_mem_s ex;
  logic       ex_valid;
  logic       stall;
  mem_to_wb_s mw;
  logic       err;
  int         total;
  int         bad;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_to_mem_i (ex),
    .ex_valid_i  (ex_valid),
    .mem_stall_o (stall),
    .mem_to_wb_o (mw),
    .mem_err_o   (err),
    .dmem        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: number of bytes touched by a funct3 code.
  function automatic int ref_nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [2:0] f3);
    int     n;
    int     off;
    longint v;
    longint lim;
    n   = ref_nbytes(f3);
    off = (n == 1) ? int'(a % 4) : (n == 2) ? int'((a % 4) / 2) * 2 : 0;
    lim = longint'(1) << (8 * n);
    v   = (longint'(rdata) >> (8 * off)) % lim;
    if (n < 4 && f3 < 3'd4 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
    int n;
    int off;
    n   = ref_nbytes(f3);
    off = (n == 1) ? int'(a % 4) : (n == 2) ? int'((a % 4) / 2) * 2 : 0;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [2:0] f3);
    int n;
    n = ref_nbytes(f3);
    if (n == 1) return (wd % 256) * 32'h0101_0101;
    if (n == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ex = '0; ex_valid = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    tick(); tick();
    total++; if (mw !== '0) begin bad++; $display("FAIL reset_wb got=%h exp=0", mw); end
    total++; if (bus.req !== 1'b0 || err !== 1'b0) begin bad++;
      $display("FAIL reset_req_err got=%b%b exp=00", bus.req, err); end
    rst_n = 1'b1;
    tick();
    total++; if (stall !== 1'b0 || mw.valid !== 1'b0) begin bad++;
      $display("FAIL reset_idle stall/valid got=%b%b exp=00", stall, mw.valid); end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 8; i++) begin
      ex = '0;
      ex.alu_result = (i == 0) ? 32'h1234 : $urandom;
      ex.rd         = (i == 0) ? 5'd5 : 5'($urandom);
      ex.reg_write  = (i == 0) ? 1'b1 : 1'($urandom);
      ex.write_data = $urandom;
      ex_valid = 1'b1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall); end
      tick();
      total++; if (mw.valid !== 1'b1 || mw.wb_data !== ex.alu_result || mw.rd !== ex.rd ||
                   mw.reg_write !== ex.reg_write || bus.req !== 1'b0) begin bad++;
        $display("FAIL alu_pass got=%b/%h/%0d/%b req=%b exp=1/%h/%0d/%b req=0",
                 mw.valid, mw.wb_data, mw.rd, mw.reg_write, bus.req,
                 ex.alu_result, ex.rd, ex.reg_write);
      end
    end
    ex_valid = 1'b0;
    tick();
    total++; if (mw.valid !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", mw.valid); end
  endtask

  task automatic test_store();
    for (int i = 0; i < 9; i++) begin
      ex = '0;
      ex.mem_write  = 1'b1;
      ex.reg_write  = 1'b1;
      ex.rd         = 5'($urandom);
      ex.alu_result = (i == 0) ? 32'h103 : $urandom;
      ex.write_data = (i == 0) ? 32'hAB : $urandom;
      ex.mem_funct3 = (i == 0) ? 3'd0 : 3'($urandom_range(0, 2));
      ex.mem_read   = 1'($urandom);
      ex_valid = 1'b1;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL st_stall got=%b exp=1", stall); end
      tick();
      ex_valid = 1'b0;
      total++; if (bus.req !== 1'b1 || bus.we !== 1'b1 ||
                   bus.addr !== {ex.alu_result[31:2], 2'b00} ||
                   bus.be !== ref_be(ex.alu_result, ex.mem_funct3) ||
                   bus.wdata !== ref_wdata(ex.write_data, ex.mem_funct3)) begin bad++;
        $display("FAIL st_bus got=%b%b %h %b %h exp=11 %h %b %h", bus.req, bus.we, bus.addr,
                 bus.be, bus.wdata, {ex.alu_result[31:2], 2'b00},
                 ref_be(ex.alu_result, ex.mem_funct3), ref_wdata(ex.write_data, ex.mem_funct3));
      end
      bus.gnt = 1'b1;
      tick();
      bus.gnt = 1'b0;
      total++; if (mw.valid !== 1'b1 || mw.reg_write !== 1'b0 || mw.rd !== ex.rd ||
                   bus.req !== 1'b0 || err !== 1'b0) begin bad++;
        $display("FAIL st_done got=%b/%b/%0d req=%b err=%b exp=1/0/%0d req=0 err=0",
                 mw.valid, mw.reg_write, mw.rd, bus.req, err, ex.rd);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] rdata;
    for (int i = 0; i < 11; i++) begin
      ex = '0;
      ex.mem_read   = 1'b1;
      ex.reg_write  = 1'b1;
      ex.rd         = 5'($urandom);
      ex.write_data = $urandom;
      case (i)
        0:       begin ex.alu_result = 32'h101; ex.mem_funct3 = 3'd0; rdata = 32'h0000_8000; end
        1:       begin ex.alu_result = 32'h101; ex.mem_funct3 = 3'd4; rdata = 32'h0000_8000; end
        2:       begin ex.alu_result = 32'h102; ex.mem_funct3 = 3'd1; rdata = 32'h8001_0000; end
        default: begin ex.alu_result = $urandom; ex.mem_funct3 = 3'($urandom); rdata = $urandom; end
      endcase
      ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0;
      total++; if (bus.req !== 1'b1 || bus.we !== 1'b0 || bus.be !== 4'b1111 ||
                   bus.addr !== {ex.alu_result[31:2], 2'b00}) begin bad++;
        $display("FAIL ld_bus got=%b%b %b %h exp=10 1111 %h", bus.req, bus.we, bus.be,
                 bus.addr, {ex.alu_result[31:2], 2'b00});
      end
      bus.gnt = 1'b1;
      tick();
      bus.gnt = 1'b0;
      total++; if (bus.req !== 1'b0 || stall !== 1'b1 || mw.valid !== 1'b0) begin bad++;
        $display("FAIL ld_wait req/stall/valid got=%b%b%b exp=010", bus.req, stall, mw.valid);
      end
      bus.rvalid = 1'b1; bus.rdata = rdata;
      tick();
      bus.rvalid = 1'b0;
      total++; if (mw.valid !== 1'b1 || mw.wb_data !== ref_load(rdata, ex.alu_result, ex.mem_funct3) ||
                   mw.rd !== ex.rd || mw.reg_write !== 1'b1) begin bad++;
        $display("FAIL ld_data f3=%0d a=%h rdata=%h got=%b/%h/%0d exp=1/%h/%0d", ex.mem_funct3,
                 ex.alu_result, rdata, mw.valid, mw.wb_data, mw.rd,
                 ref_load(rdata, ex.alu_result, ex.mem_funct3), ex.rd);
      end
    end
  endtask

  task automatic test_gnt_delay();
    logic [31:0] rdata;
    rdata = $urandom;
    ex = '0; ex.mem_read = 1'b1; ex.reg_write = 1'b1; ex.rd = 5'd9;
    ex.mem_funct3 = 3'd2; ex.alu_result = 32'h0000_0200;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.req !== 1'b1 || bus.addr !== 32'h200 || stall !== 1'b1) begin bad++;
        $display("FAIL gnt_hold c=%0d req/stall got=%b%b addr=%h exp=11 200", c, bus.req, stall, bus.addr);
      end
      tick();
    end
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = rdata;
    tick();
    bus.rvalid = 1'b0;
    total++; if (mw.valid !== 1'b1 || mw.wb_data !== rdata || err !== 1'b0) begin bad++;
      $display("FAIL gnt_delay_result got=%b/%h err=%b exp=1/%h err=0", mw.valid, mw.wb_data, err, rdata);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    ex = '0; ex.mem_read = 1'b1; ex.reg_write = 1'b1; ex.rd = 5'd3;
    ex.mem_funct3 = 3'd2; ex.alu_result = 32'h400;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    cyc = 0;
    while (err !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    total++; if (err !== 1'b1 || cyc != TMO + 1) begin bad++;
      $display("FAIL timeout_err got err=%b after %0d cycles exp err=1 after %0d", err, cyc, TMO + 1);
    end
    total++; if (mw.valid !== 1'b1 || mw.reg_write !== 1'b0 || mw.wb_data !== 32'd0 ||
                 bus.req !== 1'b0) begin bad++;
      $display("FAIL timeout_wb got=%b/%b/%h req=%b exp=1/0/0 req=0", mw.valid, mw.reg_write,
               mw.wb_data, bus.req);
    end
    ex = '0; ex.alu_result = 32'hCAFE; ex.rd = 5'd1; ex.reg_write = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    total++; if (err !== 1'b0 || mw.valid !== 1'b1 || mw.wb_data !== 32'hCAFE) begin bad++;
      $display("FAIL timeout_next got err=%b valid=%b data=%h exp 0/1/cafe", err, mw.valid, mw.wb_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rdata;
    rdata = $urandom;
    ex = '0; ex.mem_write = 1'b1; ex.mem_funct3 = 3'd2; ex.alu_result = 32'h800;
    ex.write_data = $urandom; ex.rd = 5'd4;
    ex_valid = 1'b1;
    tick();
    bus.gnt = 1'b1;
    ex_valid = 1'b0;
    tick();
    bus.gnt = 1'b0;
    ex = '0; ex.mem_read = 1'b1; ex.reg_write = 1'b1; ex.rd = 5'd7;
    ex.mem_funct3 = 3'd5; ex.alu_result = 32'h0000_0906;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    total++; if (bus.req !== 1'b1 || bus.we !== 1'b0 || bus.addr !== 32'h904) begin bad++;
      $display("FAIL b2b_load_req got=%b%b %h exp=10 904", bus.req, bus.we, bus.addr);
    end
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = rdata;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    total++; if (mw.valid !== 1'b1 || mw.wb_data !== ref_load(rdata, 32'h906, 3'd5) || mw.rd !== 5'd7) begin bad++;
      $display("FAIL b2b_load_data got=%b/%h/%0d exp=1/%h/7", mw.valid, mw.wb_data, mw.rd,
               ref_load(rdata, 32'h906, 3'd5));
    end
    ex = '0; ex.alu_result = 32'h55AA; ex.rd = 5'd2; ex.reg_write = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    total++; if (mw.valid !== 1'b1 || mw.wb_data !== 32'h55AA) begin bad++;
      $display("FAIL b2b_alu got=%b/%h exp=1/55aa", mw.valid, mw.wb_data);
    end
  endtask

  task automatic test_reset_in_wait();
    ex = '0; ex.mem_read = 1'b1; ex.reg_write = 1'b1; ex.rd = 5'd6;
    ex.mem_funct3 = 3'd2; ex.alu_result = 32'hA00;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus.req !== 1'b0 || stall !== 1'b0 || mw.valid !== 1'b0) begin bad++;
      $display("FAIL rst_wait_now req/stall/valid got=%b%b%b exp=000", bus.req, stall, mw.valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0;
    total++; if (mw.valid !== 1'b0 || stall !== 1'b0 || bus.req !== 1'b0) begin bad++;
      $display("FAIL rst_wait_late valid/stall/req got=%b%b%b exp=000", mw.valid, stall, bus.req);
    end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    ex = '0; ex.mem_read = 1'b1; ex.reg_write = 1'b1; ex.rd = 5'd8;
    ex.mem_funct3 = 3'd2; ex.alu_result = 32'h102;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    total++; if (bus.req !== 1'b0 || err !== 1'b1 || mw.valid !== 1'b1 ||
                 mw.reg_write !== 1'b0 || mw.wb_data !== 32'd0) begin bad++;
      $display("FAIL misalign_lw req/err/valid/rw got=%b%b%b%b data=%h exp=0110 0",
               bus.req, err, mw.valid, mw.reg_write, mw.wb_data);
    end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL misalign_pulse got=%b exp=0", err); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_gnt_delay();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
